// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage sitting directly downstream of ProgramCounter.
//   Presents pc to instruction memory over a req/ack handshake, registers the
//   returned word into the IF/ID output register (with a one-entry skid buffer
//   for decode stalls) and feeds ProgramCounter its next-sequential value.
//   The PC has no enable, so returning pc on pc_4 is how it holds.
//
// Ports
//   clk         in   1     clock, all state updates on posedge
//   reset       in   1     asynchronous, active-low reset
//   pc          in   size  current PC from ProgramCounter
//   pc_4        out  size  pc+4 when a fetch is accepted, else pc
//   flush       in   1     taken branch this cycle
//   stall       in   1     decode cannot accept IF/ID this cycle
//   imem_req    out  1     fetch request
//   imem_addr   out  size  fetch address (= pc, misaligned values pass as-is)
//   imem_ack    in   1     imem_rdata valid this cycle (may be same cycle as req)
//   imem_rdata  in   size  instruction word
//   if_valid    out  1     IF/ID holds a live instruction
//   if_instr    out  size  IF/ID instruction (NOP whenever if_valid=0)
//   if_pc       out  size  address of if_instr
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetch  out  32    saturating count of accepted fetches
//   perf_stall  out  32    saturating count of cycles with if_valid & stall
//   Neither counter is cleared by flush.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int              size = 32,
  parameter logic [size-1:0] NOP  = 32'h00000013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [size-1:0] pc,
  output logic [size-1:0] pc_4,
  input  logic            flush,
  input  logic            stall,
  output logic            imem_req,
  output logic [size-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [size-1:0] imem_rdata,
  output logic            if_valid,
  output logic [size-1:0] if_instr,
  output logic [size-1:0] if_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetch,
  output logic [31:0]     perf_stall
`endif
);

  localparam logic [size-1:0] PC_STEP = {{(size-3){1'b0}}, 3'b100};
  localparam logic [size-1:0] ZERO    = {size{1'b0}};

  // HOLD means the skid buffer is full, so no separate skid-valid flag.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic            accept_s, consume_s;
  logic            valid_r, valid_s;
  logic [size-1:0] instr_r, instr_s;
  logic [size-1:0] ifpc_r, ifpc_s;
  logic [size-1:0] skid_instr_r, skid_instr_s;
  logic [size-1:0] skid_pc_r, skid_pc_s;

  // Request is a pure decode of the state register, so it drops the moment
  // reset asserts and a late ack can never be accepted.
  assign imem_req  = (state_r == ST_REQ);
  assign imem_addr = pc;
  assign accept_s  = imem_req & imem_ack & ~flush;
  assign consume_s = valid_r & ~stall;
  assign pc_4      = accept_s ? (pc + PC_STEP) : pc;

  assign if_valid  = valid_r;
  assign if_instr  = instr_r;
  assign if_pc     = ifpc_r;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and IF/ID / skid next values; flush overrides everything.
  always_comb begin
    state_s      = state_r;
    valid_s      = valid_r;
    instr_s      = instr_r;
    ifpc_s       = ifpc_r;
    skid_instr_s = skid_instr_r;
    skid_pc_s    = skid_pc_r;
    if (flush) begin
      state_s      = ST_REQ;
      valid_s      = 1'b0;
      instr_s      = NOP;
      skid_instr_s = NOP;
      skid_pc_s    = ZERO;
    end else begin
      case (state_r)
        ST_IDLE: begin
          // One cycle for the PC reset value to settle before fetching.
          state_s = ST_REQ;
        end
        ST_REQ: begin
          if (accept_s) begin
            if (!valid_r || consume_s) begin
              valid_s = 1'b1;
              instr_s = imem_rdata;
              ifpc_s  = pc;
            end else begin
              // Output full and decode stalled: park the word, stop fetching.
              skid_instr_s = imem_rdata;
              skid_pc_s    = pc;
              state_s      = ST_HOLD;
            end
          end else if (consume_s) begin
            valid_s = 1'b0;
            instr_s = NOP;
          end else begin
            state_s = ST_REQ;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            valid_s      = 1'b1;
            instr_s      = skid_instr_r;
            ifpc_s       = skid_pc_r;
            skid_instr_s = NOP;
            skid_pc_s    = ZERO;
            state_s      = ST_REQ;
          end else begin
            state_s = ST_HOLD;
          end
        end
        default: begin
          state_s      = ST_IDLE;
          valid_s      = 1'b0;
          instr_s      = NOP;
          skid_instr_s = NOP;
          skid_pc_s    = ZERO;
        end
      endcase
    end
  end

  // IF/ID output register and skid buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r      <= 1'b0;
      instr_r      <= NOP;
      ifpc_r       <= ZERO;
      skid_instr_r <= NOP;
      skid_pc_r    <= ZERO;
    end else begin
      valid_r      <= valid_s;
      instr_r      <= instr_s;
      ifpc_r       <= ifpc_s;
      skid_instr_r <= skid_instr_s;
      skid_pc_r    <= skid_pc_s;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_stall_r;

  assign perf_fetch = perf_fetch_r;
  assign perf_stall = perf_stall_r;

  // Saturating performance counters; deliberately untouched by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_r <= 32'd0;
      perf_stall_r <= 32'd0;
    end else begin
      if (accept_s && (perf_fetch_r != 32'hFFFFFFFF)) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end
      if (valid_r && stall && (perf_stall_r != 32'hFFFFFFFF)) begin
        perf_stall_r <= perf_stall_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. The bench plays ProgramCounter (pc driven
//   by hand each cycle) and instruction memory (rdata = pc ^ 32'hC0DE0000).
//   Inputs change 1 time unit after posedge; combinational outputs are
//   checked 2 units later, registered outputs 1 unit after the next posedge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_4;
  logic        flush;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .pc_4       (pc_4),
    .flush      (flush),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
`endif
  );

  // Memory model keyed on the bench's own pc, independent of the DUT.
  assign imem_rdata = pc ^ 32'hC0DE0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic a, input logic s, input logic f);
    pc       = p;
    imem_ack = a;
    stall    = s;
    flush    = f;
    #2;
  endtask

  initial begin
    reset = 1'b0; pc = 32'd0; imem_ack = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    tick();
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instr, 32'h00000013);
    check("rst_ifpc",  if_pc, 32'd0);
    check("rst_req",   {31'd0, imem_req}, 32'd0);

    // Release: one IDLE cycle with req low, then REQ.
    reset = 1'b1;
    drive(32'h0, 1'b1, 1'b0, 1'b0);
    check("idle_req",  {31'd0, imem_req}, 32'd0);
    check("idle_pc4",  pc_4, 32'h0);
    tick();

    // Streaming with zero-wait ack.
    drive(32'h0, 1'b1, 1'b0, 1'b0);
    check("s0_req",  {31'd0, imem_req}, 32'd1);
    check("s0_pc4",  pc_4, 32'h4);
    tick();
    check("s0_valid", {31'd0, if_valid}, 32'd1);
    check("s0_ifpc",  if_pc, 32'h0);
    check("s0_instr", if_instr, 32'hC0DE0000);
    drive(32'h4, 1'b1, 1'b0, 1'b0);
    check("s1_pc4",  pc_4, 32'h8);
    tick();
    check("s1_ifpc",  if_pc, 32'h4);
    check("s1_instr", if_instr, 32'hC0DE0004);
    drive(32'h8, 1'b1, 1'b0, 1'b0);
    check("s2_pc4",  pc_4, 32'hC);
    tick();
    check("s2_ifpc",  if_pc, 32'h8);
    check("s2_instr", if_instr, 32'hC0DE0008);

    // Three wait states at 0x10.
    for (int i = 0; i < 3; i++) begin
      drive(32'h10, 1'b0, 1'b0, 1'b0);
      check("ws_pc4",  pc_4, 32'h10);
      check("ws_addr", imem_addr, 32'h10);
      check("ws_req",  {31'd0, imem_req}, 32'd1);
      tick();
      check("ws_valid", {31'd0, if_valid}, 32'd0);
      check("ws_instr", if_instr, 32'h00000013);
    end
    drive(32'h10, 1'b1, 1'b0, 1'b0);
    check("ws_ack_pc4", pc_4, 32'h14);
    tick();
    check("ws_ifpc",  if_pc, 32'h10);
    check("ws_instr_ok", if_instr, 32'hC0DE0010);

    // Stall with 0x20 in IF/ID while 0x24 is acked -> skid, HOLD.
    drive(32'h20, 1'b1, 1'b0, 1'b0);
    tick();
    check("sk_ifpc20", if_pc, 32'h20);
    drive(32'h24, 1'b1, 1'b1, 1'b0);
    check("sk_pc4_acc", pc_4, 32'h28);
    tick();
    drive(32'h28, 1'b1, 1'b1, 1'b0);
    check("hold_req", {31'd0, imem_req}, 32'd0);
    check("hold_pc4", pc_4, 32'h28);
    check("hold_ifpc", if_pc, 32'h20);
    tick();
    check("hold2_ifpc", if_pc, 32'h20);
    drive(32'h28, 1'b0, 1'b0, 1'b0);
    tick();
    check("unst_ifpc",  if_pc, 32'h24);
    check("unst_instr", if_instr, 32'hC0DE0024);
    check("unst_req",   {31'd0, imem_req}, 32'd1);
    drive(32'h28, 1'b1, 1'b0, 1'b0);
    check("nx_pc4", pc_4, 32'h2C);
    tick();
    check("nx_ifpc",  if_pc, 32'h28);
    check("nx_instr", if_instr, 32'hC0DE0028);

    // Fill the skid again, then flush with an ack in the same cycle.
    drive(32'h2C, 1'b1, 1'b1, 1'b0);
    tick();
    check("fl_hold_req", {31'd0, imem_req}, 32'd0);
    drive(32'h30, 1'b1, 1'b0, 1'b1);
    check("fl_pc4", pc_4, 32'h30);
    tick();
    check("fl_valid", {31'd0, if_valid}, 32'd0);
    check("fl_instr", if_instr, 32'h00000013);
    check("fl_req",   {31'd0, imem_req}, 32'd1);
    drive(32'h100, 1'b1, 1'b0, 1'b0);
    check("tgt_pc4", pc_4, 32'h104);
    tick();
    check("tgt_ifpc",  if_pc, 32'h100);
    check("tgt_instr", if_instr, 32'hC0DE0100);

    // Flush in REQ with ack: the ack is discarded.
    drive(32'h104, 1'b1, 1'b0, 1'b1);
    check("fr_pc4", pc_4, 32'h104);
    tick();
    check("fr_valid", {31'd0, if_valid}, 32'd0);
    check("fr_instr", if_instr, 32'h00000013);

    // Wrap and misaligned pc.
    drive(32'hFFFFFFFC, 1'b1, 1'b0, 1'b0);
    check("wrap_pc4", pc_4, 32'h0);
    tick();
    check("wrap_ifpc",  if_pc, 32'hFFFFFFFC);
    check("wrap_instr", if_instr, 32'h3F21FFFC);
    drive(32'h2, 1'b1, 1'b0, 1'b0);
    check("mis_addr", imem_addr, 32'h2);
    check("mis_pc4",  pc_4, 32'h6);
    tick();
    check("mis_ifpc", if_pc, 32'h2);

`ifdef FETCH_PERF_EN
    check("perf_fetch", perf_fetch, 32'd11);
    check("perf_stall", perf_stall, 32'd3);
`endif

    // Reset mid-REQ with an ack pending.
    drive(32'h40, 1'b0, 1'b0, 1'b0);
    check("mr_req_before", {31'd0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("mr_req_async", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    tick();
    check("mr_valid", {31'd0, if_valid}, 32'd0);
    check("mr_instr", if_instr, 32'h00000013);
    check("mr_ifpc",  if_pc, 32'h0);
    check("mr_req",   {31'd0, imem_req}, 32'd0);
`ifdef FETCH_PERF_EN
    check("mr_perf_fetch", perf_fetch, 32'd0);
    check("mr_perf_stall", perf_stall, 32'd0);
`endif
    reset = 1'b1;
    drive(32'h0, 1'b1, 1'b0, 1'b0);
    check("mr_idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    drive(32'h0, 1'b1, 1'b0, 1'b0);
    check("mr_req_again", {31'd0, imem_req}, 32'd1);
    tick();
    check("mr_ifpc_again", if_pc, 32'h0);
    check("mr_valid_again", {31'd0, if_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
